ifetch_buffer: RTL and testbench

//  Fetch-side consumer of the program counter: owns fetch_pc, issues sequential reads to the

---
 rtl/ifetch_buffer.sv | 99 +++++++++
 tb/tb_ifetch_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// Fetch front end: owns fetch_pc, issues sequential reads to a synchronous
// instruction ROM and queues the returned {pc, instr} pairs for decode.
module ifetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       dec_valid,
  output logic [31:0]                dec_pc,
  output logic [31:0]                dec_instr,
  input  logic                       dec_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  // Handshake: an entry moves to decode in any cycle where dec_valid and
  // dec_ready are both high; dec_valid never depends on dec_ready.

  logic [31:0]   fetch_pc;
  logic          req_q;
  logic [31:0]   pc_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          push;
  logic          pop;
  logic [CW:0]   credit;

  // Occupancy plus the in-flight response must stay below DEPTH, so every
  // returning word is guaranteed a free slot.
  assign credit   = {1'b0, count_q} + {{CW{1'b0}}, req_q};
  assign imem_req = !reset && !redirect_valid && (credit < DEPTH_L);
  assign imem_addr = fetch_pc;

  assign push = req_q;
  assign pop  = dec_valid && dec_ready;

  assign dec_valid = (count_q != '0);
  assign dec_pc    = dec_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign dec_instr = dec_valid ? instr_mem[rd_ptr] : 32'h0;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      pc_q     <= 32'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      // The response landing this cycle belongs to the old path and is dropped.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      req_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (imem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_q    <= 1'b1;
        pc_q     <= fetch_pc;
      end else begin
        req_q    <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid && push) begin
      pc_mem[wr_ptr]    <= pc_q;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized bench for ifetch_buffer: a queue-based model of the fetch stream
// predicts every output each cycle, with a behavioural ROM attached.
module tb_ifetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_ready(dec_ready), .count(count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1357} + 32'h0F0F_0001;
  endfunction

  // Synchronous ROM: data for an address requested in cycle t is presented in t+1.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? rom(imem_addr) : $urandom;
  end

  // Reference model state: fetch stream as a queue of {pc, instr} entries.
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch;
  bit          m_inflight;
  logic [31:0] m_inflight_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive inputs for one cycle, check outputs, then advance the model.
  task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc,
                       input bit rdy, input bit do_check);
    bit        e_req;
    bit        e_pop;
    @(negedge clk);
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    #1;
    e_req = !rst && !redir && ((exp_q.size() + int'(m_inflight)) < DEPTH);
    if (do_check) begin
      check("imem_req",  {63'd0, imem_req},  {63'd0, e_req});
      check("imem_addr", {32'd0, imem_addr}, {32'd0, m_fetch});
      check("count",     {61'd0, count},     64'(exp_q.size()));
      check("dec_valid", {63'd0, dec_valid}, {63'd0, exp_q.size() != 0});
      check("dec_pc",    {32'd0, dec_pc},    exp_q.size() != 0 ? {32'd0, exp_q[0][63:32]} : 64'd0);
      check("dec_instr", {32'd0, dec_instr}, exp_q.size() != 0 ? {32'd0, exp_q[0][31:0]}  : 64'd0);
    end
    if (rst) begin
      exp_q.delete();
      m_fetch    = RESET_PC;
      m_inflight = 1'b0;
    end else if (redir) begin
      exp_q.delete();
      m_fetch    = {rpc[31:2], 2'b00};
      m_inflight = 1'b0;
    end else begin
      e_pop = (exp_q.size() != 0) && rdy;
      if (e_pop) void'(exp_q.pop_front());
      if (m_inflight) exp_q.push_back({m_inflight_pc, rom(m_inflight_pc)});
      if (e_req) begin
        m_inflight    = 1'b1;
        m_inflight_pc = m_fetch;
        m_fetch       = m_fetch + 32'd4;
      end else begin
        m_inflight = 1'b0;
      end
    end
  endtask

  task automatic run_random(input int n, input int ready_pct, input int redir_per_mille,
                            input int reset_per_mille, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bit          r_rst;
      bit          r_red;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(999, 0) < reset_per_mille);
      r_red = ($urandom_range(999, 0) < redir_per_mille);
      r_pc  = base + 32'($urandom_range(255, 0));
      cycle(r_rst, r_red, r_pc, $urandom_range(99, 0) < ready_pct, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    m_fetch = RESET_PC; m_inflight = 1'b0; m_inflight_pc = 32'h0;
    // First edge establishes a known state; outputs are checked from then on.
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

    // Streaming with decode always ready.
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Decode stalled: fill to DEPTH, requests stop; then drain and refill.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Redirect with a full-ish FIFO and an in-flight request, unaligned target.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_3102, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Reset mid-stream.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Address wrap past 0xFFFF_FFFC.
    cycle(1'b0, 1'b1, 32'hFFFF_FFF3, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, $urandom_range(1, 0) == 1, 1'b1);

    // Randomized traffic with varied decode pressure.
    run_random(800, 90, 20, 3, 32'h0000_3100);
    run_random(800, 40, 30, 3, 32'h0000_8000);
    run_random(800, 10, 15, 5, 32'hFFFF_FF80);
    run_random(400, 70, 60, 10, 32'h0000_3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
